// File: rtl/round_robin_pesado_tester_pkg.sv
// Purpose: shared widths and helpers for the weighted round-robin arbiter pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package round_robin_pesado_tester_pkg;

    localparam int unsigned DEF_QUEUE_QUANTITY = 4;
    localparam int unsigned DEF_DATA_BITS      = 8;
    localparam int unsigned DEF_MAX_WEIGHT     = 64;
    localparam int unsigned DEF_BUF_WIDTH      = 3;

    // Width of one per-queue weight slice.
    function automatic int unsigned weight_w(input int unsigned max_weight);
        return (max_weight > 1) ? $clog2(max_weight) : 1;
    endfunction

    // Width of a queue index; at least one bit so a single-queue build stays legal.
    function automatic int unsigned sel_w(input int unsigned queue_quantity);
        return (queue_quantity > 1) ? $clog2(queue_quantity) : 1;
    endfunction

    localparam int unsigned WEIGHT_W = weight_w(DEF_MAX_WEIGHT);
    localparam int unsigned SEL_W    = sel_w(DEF_QUEUE_QUANTITY);

endpackage

// File: rtl/round_robin_pesado_tester_arb.sv
// Purpose: weighted round-robin arbiter; grants queue i for weight(i) consecutive cycles per turn.
// Latency: one cycle from inputs to registered selector/selector_enb.
// Backpressure: none; empty or zero-weight queues are skipped, enb=0 freezes the grant.
//
// Ports: clk/rst (async active-high), enb, pesos (N weights of W bits), buf_empty (N),
//        fifo_counter (occupancy, informational only), selector, selector_enb.
module round_robin_pesado
    import round_robin_pesado_tester_pkg::*;
#(
    parameter  int unsigned QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    parameter  int unsigned DATA_BITS      = DEF_DATA_BITS,
    parameter  int unsigned MAX_WEIGHT     = DEF_MAX_WEIGHT,
    parameter  int unsigned BUF_WIDTH      = DEF_BUF_WIDTH,
    localparam int unsigned W              = weight_w(MAX_WEIGHT),
    localparam int unsigned SW             = sel_w(QUEUE_QUANTITY)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic [QUEUE_QUANTITY*W-1:0]         pesos,
    input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
    input  logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter,
    output logic [SW-1:0]                       selector,
    output logic                                selector_enb
);

    logic [SW-1:0]             sel_q, sel_d;
    logic [W-1:0]              cnt_q, cnt_d;
    logic                      vld_q, vld_d;

    logic [QUEUE_QUANTITY-1:0] eligible;
    logic [W-1:0]              sel_weight;
    logic                      sel_eligible;
    logic                      search_found;
    logic [SW-1:0]             search_sel;

    // Occupancy and data width are carried through the interface but never steer the grant.
    logic unused_ok;
    assign unused_ok = ^{fifo_counter, (DATA_BITS == 0)};

    // A queue competes only when it has data and a nonzero weight.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
            eligible[i] = !buf_empty[i] && (pesos[i*W +: W] != '0);
        end
    end

    // Weight and eligibility of the currently held queue, decoded by compare
    // so a non-power-of-two queue count never indexes past the bus.
    always_comb begin
        sel_weight   = '0;
        sel_eligible = 1'b0;
        for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
            if (SW'(i) == sel_q) begin
                sel_weight   = pesos[i*W +: W];
                sel_eligible = eligible[i];
            end
        end
    end

    // Cyclic search starting at sel+1; the held queue is visited last so a
    // lone eligible queue is re-granted with a fresh turn.
    always_comb begin
        int unsigned idx;
        search_found = 1'b0;
        search_sel   = sel_q;
        idx          = 0;
        for (int unsigned k = 1; k <= QUEUE_QUANTITY; k++) begin
            idx = (32'(sel_q) + k) % QUEUE_QUANTITY;
            if (!search_found && eligible[idx[SW-1:0]]) begin
                search_found = 1'b1;
                search_sel   = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        vld_d = 1'b0;
        if (enb) begin
            if (sel_eligible && (cnt_q < sel_weight)) begin
                cnt_d = cnt_q + W'(1);
                vld_d = 1'b1;
            end else if (search_found) begin
                sel_d = search_sel;
                cnt_d = W'(1);
                vld_d = 1'b1;
            end else begin
                // Nothing to serve: hold the pointer, drop the turn count.
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    assign selector     = sel_q;
    assign selector_enb = vld_q;

endmodule

// File: rtl/round_robin_pesado_tester.sv
// Purpose: wraps two identical weighted round-robin arbiters fed by the same inputs.
// Latency: one cycle, same for both arbiter outputs.
// Backpressure: none; grants follow queue emptiness, weights and enb.
//
// Ports: clk/rst (async active-high), enb, pesos, buf_empty, fifo_counter;
//        selector/selector_enb from the primary copy, sint_selector/sint_selector_enb
//        from the secondary copy, which must track the primary cycle for cycle.
module round_robin_pesado_tester
    import round_robin_pesado_tester_pkg::*;
#(
    parameter  int unsigned QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
    parameter  int unsigned DATA_BITS      = DEF_DATA_BITS,
    parameter  int unsigned MAX_WEIGHT     = DEF_MAX_WEIGHT,
    parameter  int unsigned BUF_WIDTH      = DEF_BUF_WIDTH,
    localparam int unsigned W              = weight_w(MAX_WEIGHT),
    localparam int unsigned SW             = sel_w(QUEUE_QUANTITY)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enb,
    input  logic [QUEUE_QUANTITY*W-1:0]         pesos,
    input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
    input  logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter,
    output logic [SW-1:0]                       selector,
    output logic                                selector_enb,
    output logic [SW-1:0]                       sint_selector,
    output logic                                sint_selector_enb
);

    round_robin_pesado #(
        .QUEUE_QUANTITY (QUEUE_QUANTITY),
        .DATA_BITS      (DATA_BITS),
        .MAX_WEIGHT     (MAX_WEIGHT),
        .BUF_WIDTH      (BUF_WIDTH)
    ) u_primary (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .pesos        (pesos),
        .buf_empty    (buf_empty),
        .fifo_counter (fifo_counter),
        .selector     (selector),
        .selector_enb (selector_enb)
    );

    round_robin_pesado #(
        .QUEUE_QUANTITY (QUEUE_QUANTITY),
        .DATA_BITS      (DATA_BITS),
        .MAX_WEIGHT     (MAX_WEIGHT),
        .BUF_WIDTH      (BUF_WIDTH)
    ) u_secondary (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .pesos        (pesos),
        .buf_empty    (buf_empty),
        .fifo_counter (fifo_counter),
        .selector     (sint_selector),
        .selector_enb (sint_selector_enb)
    );

endmodule

// File: tb/tb_round_robin_pesado_tester.sv
// Purpose: directed self-checking bench for the dual weighted round-robin arbiter.
// Latency: expects each grant one cycle after the inputs that produce it.
// Backpressure: n/a.
module tb_round_robin_pesado_tester;

    localparam int N  = 4;
    localparam int W  = 6;
    localparam int SW = 2;
    localparam int BW = 3;

    // Weights {q3:6, q2:3, q1:2, q0:1}; second set removes queue 2.
    localparam logic [N*W-1:0] P_DEF = {6'd6, 6'd3, 6'd2, 6'd1};
    localparam logic [N*W-1:0] P_Z2  = {6'd6, 6'd0, 6'd2, 6'd1};

    logic            clk = 1'b0;
    logic            rst;
    logic            enb;
    logic [N*W-1:0]  pesos;
    logic [N-1:0]    buf_empty;
    logic [N*BW-1:0] fifo_counter;
    logic [SW-1:0]   selector;
    logic            selector_enb;
    logic [SW-1:0]   sint_selector;
    logic            sint_selector_enb;

    int checks   = 0;
    int failures = 0;

    round_robin_pesado_tester dut (
        .clk               (clk),
        .rst               (rst),
        .enb               (enb),
        .pesos             (pesos),
        .buf_empty         (buf_empty),
        .fifo_counter      (fifo_counter),
        .selector          (selector),
        .selector_enb      (selector_enb),
        .sint_selector     (sint_selector),
        .sint_selector_enb (sint_selector_enb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [N*W-1:0] p;
        logic [N-1:0]   be;
        logic           en;
        int             sel;
        int             vld;
        string          tag;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic [N*W-1:0] p, input logic [N-1:0] be,
                                input logic en, input int sel, input int vld,
                                input string tag);
        vec_t v;
        v.p   = p;
        v.be  = be;
        v.en  = en;
        v.sel = sel;
        v.vld = vld;
        v.tag = tag;
        vq.push_back(v);
    endfunction

    task automatic check_outs(input string tag, input int sel, input int vld);
        check_eq({tag, ".sel"},      int'(selector),          sel);
        check_eq({tag, ".enb"},      int'(selector_enb),      vld);
        check_eq({tag, ".sint_sel"}, int'(sint_selector),     sel);
        check_eq({tag, ".sint_enb"}, int'(sint_selector_enb), vld);
    endtask

    // Inputs are applied 1 time unit after a rising edge, results sampled 1 unit after the next.
    task automatic run_vec(input vec_t v, input int n);
        pesos        = v.p;
        buf_empty    = v.be;
        enb          = v.en;
        fifo_counter = 12'((n * 37) & 12'hfff);
        @(posedge clk);
        #1;
        check_outs(v.tag, v.sel, v.vld);
    endtask

    initial begin
        int seq [12];
        seq = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3};

        rst          = 1'b1;
        enb          = 1'b0;
        pesos        = P_DEF;
        buf_empty    = '1;
        fifo_counter = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 0);

        // Stimulus that would grant must be ignored while reset is held.
        enb       = 1'b1;
        buf_empty = '0;
        @(posedge clk);
        #1;
        check_outs("reset_hold", 0, 0);
        rst = 1'b0;

        // Two full weighted periods.
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 12; k++)
                add(P_DEF, 4'b0000, 1'b1, seq[k], 1, $sformatf("period%0d_%0d", r, k));

        // Queues 0/1 go empty during queue 3's turn: queue 3 unaffected.
        add(P_DEF, 4'b0000, 1'b1, 0, 1, "b1");
        add(P_DEF, 4'b0000, 1'b1, 1, 1, "b2");
        add(P_DEF, 4'b0000, 1'b1, 1, 1, "b3");
        add(P_DEF, 4'b0000, 1'b1, 2, 1, "b4");
        add(P_DEF, 4'b0000, 1'b1, 2, 1, "b5");
        add(P_DEF, 4'b0000, 1'b1, 2, 1, "b6");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "b7");
        add(P_DEF, 4'b0011, 1'b1, 3, 1, "b8_pulse");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "b9");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "b10");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "b11");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "b12");

        // Same pulse during queue 1's turn: turn cut short, queue 2 granted.
        add(P_DEF, 4'b0000, 1'b1, 0, 1, "c1");
        add(P_DEF, 4'b0000, 1'b1, 1, 1, "c2");
        add(P_DEF, 4'b0011, 1'b1, 2, 1, "c3_cut");
        add(P_DEF, 4'b0000, 1'b1, 2, 1, "c4");
        add(P_DEF, 4'b0000, 1'b1, 2, 1, "c5");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "c6");

        // Queue 3 empties mid-turn: grant moves to queue 0.
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "d1");
        add(P_DEF, 4'b1000, 1'b1, 0, 1, "d2_q3_empty");
        add(P_DEF, 4'b0000, 1'b1, 1, 1, "d3");
        add(P_DEF, 4'b0000, 1'b1, 1, 1, "d4");

        // All empty: grant drops with queue 1 held; resumes at its successor.
        add(P_DEF, 4'b1111, 1'b1, 1, 0, "e1_all_empty");
        add(P_DEF, 4'b0010, 1'b1, 2, 1, "e2_resume");
        add(P_DEF, 4'b0000, 1'b1, 2, 1, "e3");
        add(P_DEF, 4'b0000, 1'b1, 2, 1, "e4");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "e5");

        // enb low freezes the selector and suppresses the grant.
        add(P_DEF, 4'b0000, 1'b0, 3, 0, "f1_enb_off");
        add(P_DEF, 4'b0000, 1'b0, 3, 0, "f2_enb_off");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "f3_enb_on");
        add(P_DEF, 4'b0000, 1'b1, 3, 1, "f4");

        // Only queue 1 eligible: re-granted continuously.
        add(P_DEF, 4'b1101, 1'b1, 1, 1, "g1_single");
        add(P_DEF, 4'b1101, 1'b1, 1, 1, "g2");
        add(P_DEF, 4'b1101, 1'b1, 1, 1, "g3_regrant");
        add(P_DEF, 4'b1101, 1'b1, 1, 1, "g4");

        // Queue 2 weight forced to zero: never served.
        add(P_Z2, 4'b0000, 1'b1, 3, 1, "h1_skip2");
        add(P_Z2, 4'b0000, 1'b1, 3, 1, "h2");
        add(P_Z2, 4'b0000, 1'b1, 3, 1, "h3");
        add(P_Z2, 4'b0000, 1'b1, 3, 1, "h4");
        add(P_Z2, 4'b0000, 1'b1, 3, 1, "h5");
        add(P_Z2, 4'b0000, 1'b1, 3, 1, "h6");
        add(P_Z2, 4'b0000, 1'b1, 0, 1, "h7");
        add(P_Z2, 4'b0000, 1'b1, 1, 1, "h8");
        add(P_Z2, 4'b0000, 1'b1, 1, 1, "h9");
        add(P_Z2, 4'b0000, 1'b1, 3, 1, "h10_skip2");

        for (int i = 0; i < vq.size(); i++)
            run_vec(vq[i], i);

        // Reset mid-sequence, checked before any further clock edge.
        #1;
        rst = 1'b1;
        #1;
        check_outs("async_reset", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        vq.delete();
        add(P_DEF, 4'b0000, 1'b1, 0, 1, "post_reset_1");
        add(P_DEF, 4'b0000, 1'b1, 1, 1, "post_reset_2");
        for (int i = 0; i < vq.size(); i++)
            run_vec(vq[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
